// File: rtl/cdb_broadcaster_pkg.sv
// Shared completion-stage definitions: FU indices, completion and CDB tag packets.
// Also used by the reservation stations and the FU wrappers.
package cdb_broadcaster_pkg;

    localparam int unsigned FU_NUM   = 8;
    localparam int unsigned CDB_W    = 3;
    localparam int unsigned PR_W     = 6;
    localparam int unsigned XLEN     = 32;
    localparam int unsigned PTR_W    = $clog2(FU_NUM);
    localparam int unsigned SLOT_W   = $clog2(CDB_W);
    localparam int unsigned FU_PKT_W = 1 + PR_W + XLEN;

    typedef enum logic [PTR_W-1:0] {
        FU_ALU_1,
        FU_ALU_2,
        FU_ALU_3,
        FU_LS_1,
        FU_LS_2,
        FU_MULT_1,
        FU_MULT_2,
        FU_BRANCH
    } fu_idx_e;

    typedef struct packed {
        logic            done;
        logic [PR_W-1:0] dest_tag;
        logic [XLEN-1:0] value;
    } fu_complete_packet_t;

    // t0 occupies the most significant bits of the bus.
    typedef struct packed {
        logic [PR_W-1:0] t0;
        logic [PR_W-1:0] t1;
        logic [PR_W-1:0] t2;
    } cdb_t_packet_t;

endpackage

// File: rtl/cdb_broadcaster_rr_picker.sv
// Rotating-priority picker: grants the first CDB_W requesters found scanning upward from ptr.
// Purely combinational; shared with the RS issue select.
module cdb_broadcaster_rr_picker
    import cdb_broadcaster_pkg::*;
(
    input  logic [FU_NUM-1:0]             req,
    input  logic [PTR_W-1:0]              ptr,
    output logic [CDB_W-1:0][FU_NUM-1:0]  grant,
    output logic [PTR_W-1:0]              next_ptr
);

    int cnt;
    int idx;

    always_comb begin
        grant    = '0;
        next_ptr = ptr;
        cnt      = 0;
        idx      = 0;
        for (int k = 0; k < int'(FU_NUM); k++) begin
            idx = (int'(ptr) + k) % int'(FU_NUM);
            if (req[idx[PTR_W-1:0]] && (cnt < int'(CDB_W))) begin
                grant[cnt[SLOT_W-1:0]][idx[PTR_W-1:0]] = 1'b1;
                next_ptr = PTR_W'((idx + 1) % int'(FU_NUM));
                cnt      = cnt + 1;
            end
        end
    end

endmodule

// File: rtl/cdb_broadcaster.sv
// Complete stage: arbitrates FU results onto the CDB and the PRF write ports.
// Losing FUs park their result in a hold register and are stalled until granted.
module cdb_broadcaster
    import cdb_broadcaster_pkg::*;
(
    input  logic                              clock,
    input  logic                              reset,
    input  logic                              squash,
    input  logic [FU_NUM-1:0][FU_PKT_W-1:0]   fu_result,
    output logic [FU_NUM-1:0]                 fu_stall,
    output logic [CDB_W*PR_W-1:0]             cdb_t,
    output logic [CDB_W-1:0]                  wb_en,
    output logic [CDB_W-1:0][PR_W-1:0]        wb_tag,
    output logic [CDB_W-1:0][XLEN-1:0]        wb_value
);

    fu_complete_packet_t [FU_NUM-1:0] fu_pkt;

    logic [FU_NUM-1:0]            hold_valid_q, hold_valid_d;
    logic [FU_NUM-1:0][PR_W-1:0]  hold_tag_q, hold_tag_d;
    logic [FU_NUM-1:0][XLEN-1:0]  hold_value_q, hold_value_d;
    logic [PTR_W-1:0]             rr_ptr_q, rr_ptr_d;

    logic [FU_NUM-1:0]            fresh, req, granted;
    logic [FU_NUM-1:0][PR_W-1:0]  cand_tag;
    logic [FU_NUM-1:0][XLEN-1:0]  cand_value;
    logic [CDB_W-1:0][FU_NUM-1:0] grant;

    logic [CDB_W-1:0]             slot_en_d, slot_en_q;
    logic [CDB_W-1:0][PR_W-1:0]   slot_tag_d, slot_tag_q;
    logic [CDB_W-1:0][XLEN-1:0]   slot_value_d, slot_value_q;
    cdb_t_packet_t                cdb_pkt;

    assign fu_pkt = fu_result;

    // A held entry masks the live FU port; done with tag 0 never competes for a slot.
    always_comb begin
        fresh      = '0;
        cand_tag   = '0;
        cand_value = '0;
        for (int i = 0; i < int'(FU_NUM); i++) begin
            fresh[i]      = !hold_valid_q[i] && fu_pkt[i].done && (fu_pkt[i].dest_tag != '0);
            cand_tag[i]   = hold_valid_q[i] ? hold_tag_q[i] : fu_pkt[i].dest_tag;
            cand_value[i] = hold_valid_q[i] ? hold_value_q[i] : fu_pkt[i].value;
        end
        req = squash ? '0 : (hold_valid_q | fresh);
    end

    cdb_broadcaster_rr_picker u_picker (
        .req      (req),
        .ptr      (rr_ptr_q),
        .grant    (grant),
        .next_ptr (rr_ptr_d)
    );

    always_comb begin
        granted      = '0;
        slot_en_d    = '0;
        slot_tag_d   = '0;
        slot_value_d = '0;
        for (int s = 0; s < int'(CDB_W); s++) begin
            slot_en_d[s] = |grant[s];
            for (int i = 0; i < int'(FU_NUM); i++) begin
                if (grant[s][i]) begin
                    granted[i]      = 1'b1;
                    slot_tag_d[s]   = slot_tag_d[s] | cand_tag[i];
                    slot_value_d[s] = slot_value_d[s] | cand_value[i];
                end
            end
        end
    end

    always_comb begin
        hold_valid_d = req & ~granted;
        hold_tag_d   = hold_tag_q;
        hold_value_d = hold_value_q;
        for (int i = 0; i < int'(FU_NUM); i++) begin
            if (fresh[i] && !granted[i]) begin
                hold_tag_d[i]   = fu_pkt[i].dest_tag;
                hold_value_d[i] = fu_pkt[i].value;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hold_valid_q <= '0;
            hold_tag_q   <= '0;
            hold_value_q <= '0;
            rr_ptr_q     <= '0;
            slot_en_q    <= '0;
            slot_tag_q   <= '0;
            slot_value_q <= '0;
        end else begin
            hold_valid_q <= hold_valid_d;
            hold_tag_q   <= hold_tag_d;
            hold_value_q <= hold_value_d;
            rr_ptr_q     <= rr_ptr_d;
            slot_en_q    <= slot_en_d;
            slot_tag_q   <= slot_tag_d;
            slot_value_q <= slot_value_d;
        end
    end

    always_comb begin
        cdb_pkt    = '0;
        cdb_pkt.t0 = slot_tag_q[0];
        cdb_pkt.t1 = slot_tag_q[1];
        cdb_pkt.t2 = slot_tag_q[2];
    end

    assign cdb_t    = cdb_pkt;
    assign wb_en    = slot_en_q;
    assign wb_tag   = slot_tag_q;
    assign wb_value = slot_value_q;
    assign fu_stall = hold_valid_q;

    for (genvar i = 0; i < FU_NUM; i++) begin : g_stall_chk
        a_no_done_while_stalled: assert property (
            @(posedge clock) disable iff (!reset) !(hold_valid_q[i] && fu_pkt[i].done)
        );
    end

    for (genvar s = 0; s < CDB_W; s++) begin : g_dup_chk
        for (genvar t = s + 1; t < CDB_W; t++) begin : g_pair
            a_unique_tags: assert property (
                @(posedge clock) disable iff (!reset)
                !((slot_tag_q[s] != '0) && (slot_tag_q[s] == slot_tag_q[t]))
            );
        end
    end

endmodule

// File: tb/tb_cdb_broadcaster.sv
// Directed bench for cdb_broadcaster: table of per-cycle vectors plus hand-written
// sequences for reset release, latency and asynchronous reset mid-stall.
module tb_cdb_broadcaster;
    import cdb_broadcaster_pkg::*;

    logic                             clock;
    logic                             reset;
    logic                             squash;
    logic [FU_NUM-1:0][FU_PKT_W-1:0]  fu_result;
    logic [FU_NUM-1:0]                fu_stall;
    logic [CDB_W*PR_W-1:0]            cdb_t;
    logic [CDB_W-1:0]                 wb_en;
    logic [CDB_W-1:0][PR_W-1:0]       wb_tag;
    logic [CDB_W-1:0][XLEN-1:0]       wb_value;

    int n_pass  = 0;
    int n_total = 0;

    cdb_broadcaster dut (
        .clock     (clock),
        .reset     (reset),
        .squash    (squash),
        .fu_result (fu_result),
        .fu_stall  (fu_stall),
        .cdb_t     (cdb_t),
        .wb_en     (wb_en),
        .wb_tag    (wb_tag),
        .wb_value  (wb_value)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One cycle of stimulus: done mask, tags packed FU7..FU0, squash; expected
    // tags packed {slot0, slot1, slot2} and expected fu_stall after the edge.
    typedef struct {
        logic [7:0]  done;
        logic [47:0] tags;
        logic        sq;
        logic [17:0] exp_t;
        logic [7:0]  exp_stall;
    } vec_t;

    vec_t vecs [14];

    function automatic logic [31:0] val_of(input logic [5:0] t);
        return 32'hC0DE_0000 | {18'd0, t, 8'h5A};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
        else n_pass++;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic [7:0] done, input logic [47:0] tags, input logic sq);
        logic [5:0] t;
        squash = sq;
        for (int i = 0; i < 8; i++) begin
            t = tags[i*6 +: 6];
            fu_result[i] = done[i] ? {1'b1, t, val_of(t)} : '0;
        end
    endtask

    task automatic check_vec(input string name, input logic [17:0] exp_t, input logic [7:0] st);
        logic [5:0]  s0, s1, s2;
        logic [95:0] ev;
        s0 = exp_t[17:12];
        s1 = exp_t[11:6];
        s2 = exp_t[5:0];
        ev = {(s2 != 0) ? val_of(s2) : 32'd0, (s1 != 0) ? val_of(s1) : 32'd0,
              (s0 != 0) ? val_of(s0) : 32'd0};
        chk({name, " cdb_t"}, 128'(cdb_t), 128'(exp_t));
        chk({name, " wb_en"}, 128'(wb_en), 128'({s2 != 0, s1 != 0, s0 != 0}));
        chk({name, " wb_tag"}, 128'(wb_tag), 128'({s2, s1, s0}));
        chk({name, " wb_value"}, 128'(wb_value), 128'(ev));
        chk({name, " fu_stall"}, 128'(fu_stall), 128'(st));
    endtask

    initial begin
        reset     = 1'b0;
        squash    = 1'b0;
        fu_result = '0;

        vecs[0]  = '{8'h80, {6'd20, 42'd0}, 1'b0, {6'd20, 12'd0}, 8'h00};
        vecs[1]  = '{8'hFF, {6'd8, 6'd7, 6'd6, 6'd5, 6'd4, 6'd3, 6'd2, 6'd1}, 1'b0,
                     {6'd1, 6'd2, 6'd3}, 8'hF8};
        vecs[2]  = '{8'h00, 48'd0, 1'b0, {6'd4, 6'd5, 6'd6}, 8'hC0};
        vecs[3]  = '{8'h00, 48'd0, 1'b0, {6'd7, 6'd8, 6'd0}, 8'h00};
        vecs[4]  = '{8'h20, {12'd0, 6'd21, 30'd0}, 1'b0, {6'd21, 12'd0}, 8'h00};
        vecs[5]  = '{8'hC3, {6'd8, 6'd7, 24'd0, 6'd2, 6'd1}, 1'b0, {6'd7, 6'd8, 6'd1}, 8'h02};
        vecs[6]  = '{8'h00, 48'd0, 1'b0, {6'd2, 12'd0}, 8'h00};
        vecs[7]  = '{8'h28, {12'd0, 6'd9, 30'd0}, 1'b0, {6'd9, 12'd0}, 8'h00};
        vecs[8]  = '{8'h3F, {12'd0, 6'd15, 6'd14, 6'd13, 6'd12, 6'd11, 6'd10}, 1'b0,
                     {6'd10, 6'd11, 6'd12}, 8'h38};
        vecs[9]  = '{8'h00, 48'd0, 1'b1, 18'd0, 8'h00};
        vecs[10] = '{8'h00, 48'd0, 1'b0, 18'd0, 8'h00};
        vecs[11] = '{8'h11, {18'd0, 6'd31, 18'd0, 6'd30}, 1'b0, {6'd31, 6'd30, 6'd0}, 8'h00};
        vecs[12] = '{8'h02, {36'd0, 6'd40, 6'd0}, 1'b1, 18'd0, 8'h00};
        vecs[13] = '{8'h00, 48'd0, 1'b0, 18'd0, 8'h00};

        #12;
        chk("reset cdb_t", 128'(cdb_t), 128'd0);
        chk("reset wb_en", 128'(wb_en), 128'd0);
        chk("reset wb_value", 128'(wb_value), 128'd0);
        chk("reset fu_stall", 128'(fu_stall), 128'd0);

        // Release, idle one cycle, then ALU_1 completes tag 5 with value 0x11.
        reset = 1'b1;
        step();
        check_vec("idle", 18'd0, 8'h00);
        fu_result[0] = {1'b1, 6'd5, 32'h11};
        step();
        chk("lat cdb_t", 128'(cdb_t), 128'({6'd5, 12'd0}));
        chk("lat wb_en", 128'(wb_en), 128'(3'b001));
        chk("lat wb_value", 128'(wb_value), 128'({32'd0, 32'd0, 32'h11}));
        chk("lat fu_stall", 128'(fu_stall), 128'd0);
        fu_result = '0;
        step();
        check_vec("lat done", 18'd0, 8'h00);

        for (int v = 0; v < 14; v++) begin
            drive(vecs[v].done, vecs[v].tags, vecs[v].sq);
            step();
            check_vec($sformatf("vec%0d", v), vecs[v].exp_t, vecs[v].exp_stall);
        end
        drive(8'h00, 48'd0, 1'b0);

        // Build up held entries on FU0/4/5, then hit asynchronous reset mid-cycle.
        drive(8'h3F, {12'd0, 6'd55, 6'd54, 6'd53, 6'd52, 6'd51, 6'd50}, 1'b0);
        step();
        check_vec("prerst", {6'd51, 6'd52, 6'd53}, 8'h31);
        drive(8'h00, 48'd0, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        chk("async cdb_t", 128'(cdb_t), 128'd0);
        chk("async wb_en", 128'(wb_en), 128'd0);
        chk("async fu_stall", 128'(fu_stall), 128'd0);
        #2;
        reset = 1'b1;
        step();
        check_vec("postrst1", 18'd0, 8'h00);
        step();
        check_vec("postrst2", 18'd0, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
